// File: rtl/pet_stat_engine_pkg.sv
// Shared constants and helpers for the pet stat engine.
// Holds the health index, default sizing and the saturating clamp used by every stat.
package pet_pkg;

    localparam int HEALTH_IDX     = 0;
    localparam int DEF_STAT_W     = 4;
    localparam int DEF_NUM_STATS  = 6;
    localparam int DEF_CRIT_LEVEL = 2;

    // Clamp a signed intermediate result into the unsigned range [0, 2^width-1].
    function automatic logic [31:0] sat_clamp(input logic signed [31:0] value, input int width);
        longint      maxVal;
        logic [31:0] result;
        maxVal = (longint'(1) << width) - 1;
        if (value < 0) begin
            result = '0;
        end else if (longint'(value) > maxVal) begin
            result = 32'(maxVal);
        end else begin
            result = 32'(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/pet_stat_engine_tick_prescaler.sv
// Free-running decay tick divider.
// Counts 0..DIV-1 while run is high and flags the last count as a one-cycle tick.
module tick_prescaler #(
    parameter int DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = run && (count_q == LAST);

    // Advance the count only while running; wrap to zero on the tick cycle.
    always_comb begin
        count_d = count_q;
        if (run) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    // Count register, cleared immediately by reset so the first tick is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pet_stat_engine.sv
// Pet stat engine: a bank of saturating stat counters with random decay and button boosts.
// Stat 0 is health, which heals or decays depending on whether any other stat is critical.
// Once health hits zero the pet is dead until reset, and everything freezes.
module pet_stat_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS  = DEF_NUM_STATS,
    parameter int STAT_W     = DEF_STAT_W,
    parameter int TICK_DIV   = 10_000_000,
    parameter int ACT_GAIN   = 4,
    parameter int CRIT_LEVEL = DEF_CRIT_LEVEL,
    parameter int INIT_LEVEL = 8,
    parameter int RAND_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [NUM_STATS-1:0]          action_i,
    input  logic [RAND_W-1:0]             rand_i,
    output logic [NUM_STATS*STAT_W-1:0]   stats_o,
    output logic [NUM_STATS-1:0]          critical_o,
    output logic                          alive_o,
    output logic                          tick_o
);

    localparam int                       SUM_W  = STAT_W + 2;
    localparam logic signed [SUM_W-1:0]  GAIN_S = SUM_W'(ACT_GAIN);
    localparam logic signed [SUM_W-1:0]  ONE_S  = SUM_W'(1);
    localparam logic [STAT_W-1:0]        INIT_V = STAT_W'(INIT_LEVEL);

    logic [STAT_W-1:0]        stat_q [NUM_STATS];
    logic [STAT_W-1:0]        stat_d [NUM_STATS];
    logic signed [SUM_W-1:0]  sum    [NUM_STATS];
    logic [NUM_STATS-1:0]     actPrev_q;
    logic                     dead_q;
    logic [NUM_STATS-1:0]     critical;
    logic [NUM_STATS-1:0]     edges;
    logic                     anyCrit;
    logic                     alive;
    logic                     run;
    logic                     tick;
    logic                     unusedRand;

    // Random bits above NUM_STATS are not consumed by any stat.
    assign unusedRand = ^rand_i;

    // Critical flags come straight from the registered stats.
    always_comb begin
        critical = '0;
        for (int k = 0; k < NUM_STATS; k++) begin
            critical[k] = (int'(stat_q[k]) < CRIT_LEVEL);
        end
    end

    assign anyCrit = |critical[NUM_STATS-1:1];
    assign alive   = !dead_q && (stat_q[HEALTH_IDX] != '0);
    assign run     = ena && alive;
    assign edges   = action_i & ~actPrev_q & {NUM_STATS{run}};

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .tick (tick)
    );

    // Sum boost and decay terms in widened signed arithmetic, then saturate back to a stat.
    always_comb begin
        for (int k = 0; k < NUM_STATS; k++) begin
            sum[k] = signed'({2'b00, stat_q[k]});
            if (edges[k]) begin
                sum[k] = sum[k] + GAIN_S;
            end
            if (tick) begin
                if (k == HEALTH_IDX) begin
                    if (anyCrit) begin
                        sum[k] = sum[k] - ONE_S;
                    end else if (rand_i[HEALTH_IDX]) begin
                        sum[k] = sum[k] + ONE_S;
                    end
                end else if (rand_i[k]) begin
                    sum[k] = sum[k] - ONE_S;
                end
            end
            stat_d[k] = STAT_W'(sat_clamp(32'(sum[k]), STAT_W));
        end
    end

    // Stat registers; without a tick or edge the next value equals the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STATS; k++) begin
                stat_q[k] <= INIT_V;
            end
        end else begin
            for (int k = 0; k < NUM_STATS; k++) begin
                stat_q[k] <= stat_d[k];
            end
        end
    end

    // Button history tracks the pins every cycle so a held button never re-triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            actPrev_q <= '0;
        end else begin
            actPrev_q <= action_i;
        end
    end

    // Sticky death flag, set the clock after health reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_q <= 1'b0;
        end else if (stat_q[HEALTH_IDX] == '0) begin
            dead_q <= 1'b1;
        end
    end

    // Pack the stat registers onto the output bus.
    always_comb begin
        stats_o = '0;
        for (int k = 0; k < NUM_STATS; k++) begin
            stats_o[k*STAT_W +: STAT_W] = stat_q[k];
        end
    end

    assign critical_o = critical;
    assign alive_o    = alive;
    assign tick_o     = tick;

endmodule
